// File: rtl/operand_stage_if.sv
// Operand-stage bus bundle: register-file write/read controls, operand selects, ALU operands.
// Latency: none of its own; it is a wire bundle.
// Backpressure: take from the ALU is the only return-direction control; opnd_valid qualifies Ain/Bin.
interface operand_stage_if;
    logic        write;
    logic [2:0]  writenum;
    logic [15:0] data_in;
    logic [2:0]  readnum;
    logic        loada;
    logic        loadb;
    logic [1:0]  shift;
    logic        asel;
    logic        bsel;
    logic [15:0] sximm5;
    logic        take;
    logic [15:0] Ain;
    logic [15:0] Bin;
    logic        opnd_valid;

    // Stimulus / controller side
    modport master (
        output write, writenum, data_in, readnum, loada, loadb,
        output shift, asel, bsel, sximm5, take,
        input  Ain, Bin, opnd_valid
    );

    // Operand stage side
    modport slave (
        input  write, writenum, data_in, readnum, loada, loadb,
        input  shift, asel, bsel, sximm5, take,
        output Ain, Bin, opnd_valid
    );
endinterface

// File: rtl/operand_stage.sv
// Operand stage: 8x16 register file, A/B operand registers, B shifter, operand muxes, load tracking FSM.
// Latency: loads land one edge after request; Ain/Bin are combinational from A/B and the selects.
// Backpressure: opnd_valid holds until take; loads in READY overwrite, take with loads consumes then reloads.
module operand_stage (
    input  logic           clk,
    input  logic           reset_n,
    operand_stage_if.slave opif
);

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_HAVE_A = 2'd1;
    localparam logic [1:0] ST_HAVE_B = 2'd2;
    localparam logic [1:0] ST_READY  = 2'd3;

    logic [15:0] regs_q [8];
    logic [15:0] regs_d [8];
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [1:0]  state_q, state_d;
    logic [15:0] rd_dat;
    logic [15:0] b_shf;

    // Next state when starting from nothing loaded (also used after a take in READY)
    function automatic logic [1:0] load_next(input logic la, input logic lb);
        logic [1:0] nxt;
        case ({la, lb})
            2'b11:   nxt = ST_READY;
            2'b10:   nxt = ST_HAVE_A;
            2'b01:   nxt = ST_HAVE_B;
            default: nxt = ST_EMPTY;
        endcase
        return nxt;
    endfunction

    // Combinational read sees the pre-write contents, so same-edge loads capture old data
    always_comb begin
        rd_dat = regs_q[opif.readnum];
    end

    // Register file write and operand register capture
    always_comb begin
        regs_d = regs_q;
        if (opif.write) begin
            regs_d[opif.writenum] = opif.data_in;
        end
        a_d = opif.loada ? rd_dat : a_q;
        b_d = opif.loadb ? rd_dat : b_q;
    end

    // Tracking FSM; take only matters in READY
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                state_d = load_next(opif.loada, opif.loadb);
            end
            ST_HAVE_A: begin
                if (opif.loadb) begin
                    state_d = ST_READY;
                end
            end
            ST_HAVE_B: begin
                if (opif.loada) begin
                    state_d = ST_READY;
                end
            end
            default: begin
                if (opif.take) begin
                    state_d = load_next(opif.loada, opif.loadb);
                end
            end
        endcase
    end

    // State update; reset wins over every other control in the same cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 16'h0000;
            end
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            state_q <= ST_EMPTY;
        end else begin
            regs_q  <= regs_d;
            a_q     <= a_d;
            b_q     <= b_d;
            state_q <= state_d;
        end
    end

    // B-path shifter: none, shift left, logical right, arithmetic right
    always_comb begin
        case (opif.shift)
            2'b01:   b_shf = {b_q[14:0], 1'b0};
            2'b10:   b_shf = {1'b0, b_q[15:1]};
            2'b11:   b_shf = {b_q[15], b_q[15:1]};
            default: b_shf = b_q;
        endcase
    end

    assign opif.Ain        = opif.asel ? 16'h0000 : a_q;
    assign opif.Bin        = opif.bsel ? opif.sximm5 : b_shf;
    assign opif.opnd_valid = (state_q == ST_READY);

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: table of per-cycle vectors plus a hand-written valid-timing sequence.
// Each vector is driven just after a rising edge, and its outputs are checked 1 time unit after the next edge.
// Expected values are hand-computed from the register/operand/FSM behaviour.
module tb_operand_stage;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    operand_stage_if opif ();

    operand_stage dut (
        .clk     (clk),
        .reset_n (reset_n),
        .opif    (opif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        wr;
        logic [2:0]  wnum;
        logic [15:0] wdat;
        logic [2:0]  rnum;
        logic        la;
        logic        lb;
        logic [1:0]  sh;
        logic        as;
        logic        bs;
        logic [15:0] imm;
        logic        tk;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic        exp_v;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst_n, input logic wr, input logic [2:0] wnum, input logic [15:0] wdat,
        input logic [2:0] rnum, input logic la, input logic lb, input logic [1:0] sh,
        input logic as, input logic bs, input logic [15:0] imm, input logic tk,
        input logic [15:0] exp_a, input logic [15:0] exp_b, input logic exp_v);
        vec_t v;
        v.rst_n = rst_n; v.wr = wr; v.wnum = wnum; v.wdat = wdat;
        v.rnum = rnum; v.la = la; v.lb = lb; v.sh = sh;
        v.as = as; v.bs = bs; v.imm = imm; v.tk = tk;
        v.exp_a = exp_a; v.exp_b = exp_b; v.exp_v = exp_v;
        return v;
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset_n       = v.rst_n;
        opif.write    = v.wr;
        opif.writenum = v.wnum;
        opif.data_in  = v.wdat;
        opif.readnum  = v.rnum;
        opif.loada    = v.la;
        opif.loadb    = v.lb;
        opif.shift    = v.sh;
        opif.asel     = v.as;
        opif.bsel     = v.bs;
        opif.sximm5   = v.imm;
        opif.take     = v.tk;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        //            rst wr wn  wdat      rn la lb sh    as bs imm       tk  Ain       Bin       v
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 2'b00, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0)); // 0 reset
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 2'b00, 0, 1, 16'hFFFE, 0, 16'h0000, 16'hFFFE, 0)); // 1 reset, bsel
        vecs.push_back(mk(1, 1, 3, 16'h0007, 0, 0, 0, 2'b00, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0)); // 2 R3=7
        vecs.push_back(mk(1, 1, 5, 16'h0003, 0, 0, 0, 2'b00, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0)); // 3 R5=3
        vecs.push_back(mk(1, 0, 0, 16'h0000, 3, 1, 0, 2'b00, 0, 0, 16'h0000, 0, 16'h0007, 16'h0000, 0)); // 4 loada -> HAVE_A
        vecs.push_back(mk(1, 0, 0, 16'h0000, 5, 0, 1, 2'b00, 0, 0, 16'h0000, 0, 16'h0007, 16'h0003, 1)); // 5 loadb -> READY
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 2'b00, 0, 0, 16'h0000, 0, 16'h0007, 16'h0003, 1)); // 6 hold
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 2'b00, 0, 0, 16'h0000, 1, 16'h0007, 16'h0003, 0)); // 7 take -> EMPTY
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 2'b00, 0, 0, 16'h0000, 1, 16'h0007, 16'h0003, 0)); // 8 take ignored
        vecs.push_back(mk(1, 1, 1, 16'h8001, 0, 0, 0, 2'b00, 0, 0, 16'h0000, 0, 16'h0007, 16'h0003, 0)); // 9 R1=8001
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 1, 2'b00, 0, 0, 16'h0000, 0, 16'h0007, 16'h8001, 0)); // 10 HAVE_B
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 2'b01, 0, 0, 16'h0000, 1, 16'h0007, 16'h0002, 0)); // 11 shl, take ignored
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 2'b10, 0, 0, 16'h0000, 0, 16'h0007, 16'h4000, 0)); // 12 lsr
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 2'b11, 0, 0, 16'h0000, 0, 16'h0007, 16'hC000, 0)); // 13 asr
        vecs.push_back(mk(1, 0, 0, 16'h0000, 3, 1, 0, 2'b00, 0, 0, 16'h0000, 0, 16'h0007, 16'h8001, 1)); // 14 loada -> READY
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 2'b00, 1, 1, 16'hFFFE, 0, 16'h0000, 16'hFFFE, 1)); // 15 asel/bsel
        vecs.push_back(mk(1, 0, 0, 16'h0000, 5, 1, 0, 2'b00, 0, 0, 16'h0000, 1, 16'h0003, 16'h8001, 0)); // 16 take+loada -> HAVE_A
        vecs.push_back(mk(1, 0, 0, 16'h0000, 3, 0, 1, 2'b00, 0, 0, 16'h0000, 0, 16'h0003, 16'h0007, 1)); // 17 loadb -> READY
        vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 1, 2'b00, 0, 0, 16'h0000, 1, 16'h8001, 16'h8001, 1)); // 18 take+both -> READY
        vecs.push_back(mk(1, 0, 0, 16'h0000, 5, 1, 0, 2'b00, 0, 0, 16'h0000, 0, 16'h0003, 16'h8001, 1)); // 19 overwrite in READY
        vecs.push_back(mk(1, 1, 2, 16'h00AA, 0, 0, 0, 2'b00, 0, 0, 16'h0000, 0, 16'h0003, 16'h8001, 1)); // 20 R2=00AA
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 2'b00, 0, 0, 16'h0000, 1, 16'h0003, 16'h8001, 0)); // 21 take -> EMPTY
        vecs.push_back(mk(1, 1, 2, 16'h1234, 2, 1, 0, 2'b00, 0, 0, 16'h0000, 0, 16'h00AA, 16'h8001, 0)); // 22 write+read old
        vecs.push_back(mk(1, 0, 0, 16'h0000, 2, 1, 0, 2'b00, 0, 0, 16'h0000, 0, 16'h1234, 16'h8001, 0)); // 23 R2 now 1234
        vecs.push_back(mk(1, 0, 0, 16'h0000, 3, 0, 1, 2'b00, 0, 0, 16'h0000, 0, 16'h1234, 16'h0007, 1)); // 24 READY
        vecs.push_back(mk(0, 1, 3, 16'hFFFF, 3, 1, 1, 2'b00, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 0)); // 25 reset beats all
        vecs.push_back(mk(1, 0, 0, 16'h0000, 3, 1, 1, 2'b00, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1)); // 26 R3 cleared, no write
        vecs.push_back(mk(1, 0, 0, 16'h0000, 5, 1, 1, 2'b00, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 1)); // 27 R5 cleared
        vecs.push_back(mk(1, 1, 4, 16'h5555, 0, 0, 0, 2'b00, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 0)); // 28 R4=5555, take
        vecs.push_back(mk(1, 0, 0, 16'h0000, 4, 1, 0, 2'b00, 0, 0, 16'h0000, 0, 16'h5555, 16'h0000, 0)); // 29 HAVE_A
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 2'b00, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0)); // 30 reset mid-seq
        vecs.push_back(mk(1, 0, 0, 16'h0000, 4, 0, 1, 2'b00, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0)); // 31 HAVE_B only
        vecs.push_back(mk(1, 0, 0, 16'h0000, 4, 1, 0, 2'b00, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1)); // 32 READY

        drive(vecs[0]);
        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check16($sformatf("vec%0d Ain", i), opif.Ain, vecs[i].exp_a);
            check16($sformatf("vec%0d Bin", i), opif.Bin, vecs[i].exp_b);
            check1($sformatf("vec%0d opnd_valid", i), opif.opnd_valid, vecs[i].exp_v);
        end

        // opnd_valid rises only on the edge that completes the loads; data appears with it
        drive(mk(1, 1, 6, 16'h00F0, 0, 0, 0, 2'b00, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 0));
        @(posedge clk);
        #1;
        check1("seq take->empty", opif.opnd_valid, 1'b0);
        drive(mk(1, 0, 0, 16'h0000, 6, 1, 1, 2'b00, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0));
        #1;
        check1("seq valid before edge", opif.opnd_valid, 1'b0);
        check16("seq Ain before edge", opif.Ain, 16'h0000);
        @(posedge clk);
        #1;
        check1("seq valid after edge", opif.opnd_valid, 1'b1);
        check16("seq Ain after edge", opif.Ain, 16'h00F0);
        check16("seq Bin after edge", opif.Bin, 16'h00F0);
        opif.loada = 1'b0;
        opif.loadb = 1'b0;
        opif.take  = 1'b1;
        #1;
        check1("seq valid held until edge", opif.opnd_valid, 1'b1);
        @(posedge clk);
        #1;
        check1("seq valid dropped", opif.opnd_valid, 1'b0);
        check16("seq A kept after take", opif.Ain, 16'h00F0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
